clock_time_setter: RTL and testbench

- Button-driven controller that sequences time setting for the digital clock's BCD counter chain (sec1/sec10/min1/min10/hour1/hour10).
- In RUN mode it lets the counters free-run. In a SET mode it freezes the counters and edits a shadow copy of hh:mm:ss with increment/decrement and auto-repeat.
- On exit it issues a one-cycle load to the counters and drives a per-field blink mask for the segment and text display.

---
 rtl/clock_time_setter.sv | 178 +++++++++++++++++
 tb/tb_clock_time_setter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_setter.sv
// Time-setting controller for the BCD clock counter chain: freezes the counters,
// edits a shadow hh:mm:ss with inc/dec plus auto-repeat, and strobes load on exit.
module clock_time_setter #(
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter int BLINK_HALF    = 6_250_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_sec1,
    input  logic [3:0] cur_sec10,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min10,
    input  logic [3:0] cur_hour1,
    input  logic [3:0] cur_hour10,
    output logic [3:0] set_sec1,
    output logic [3:0] set_sec10,
    output logic [3:0] set_min1,
    output logic [3:0] set_min10,
    output logic [3:0] set_hour1,
    output logic [3:0] set_hour10,
    output logic       load,
    output logic       run_en,
    output logic [1:0] mode,
    output logic [2:0] blink_mask
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

    // The state encoding doubles as the mode output.
    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;

    state_t        state, state_d;
    logic          mode_q, inc_q, dec_q;
    logic          load_d;
    logic [3:0]    h10_d, h1_d, m10_d, m1_d, s10_d, s1_d;
    logic [RW-1:0] rep_cnt, rep_cnt_d;
    logic          rep_per, rep_per_d;
    logic [BW-1:0] blink_cnt, blink_cnt_d;
    logic          blink_phase, blink_phase_d;
    logic          mode_edge, inc_edge, dec_edge;
    logic          step, step_up;

    assign mode_edge = btn_mode & ~mode_q;
    assign inc_edge  = btn_inc & ~inc_q;
    assign dec_edge  = btn_dec & ~dec_q;

    // Two-digit BCD field treated as one value in 0..max, wrapping both ways.
    function automatic logic [7:0] bcd_step(input logic [3:0] tens, input logic [3:0] ones,
                                            input logic [6:0] max, input logic up);
        logic [6:0] v;
        v = 7'(tens) * 7'd10 + 7'(ones);
        if (up) v = (v == max) ? 7'd0 : v + 7'd1;
        else    v = (v == 7'd0) ? max : v - 7'd1;
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    always_comb begin
        state_d       = state;
        load_d        = 1'b0;
        {h10_d, h1_d} = {set_hour10, set_hour1};
        {m10_d, m1_d} = {set_min10, set_min1};
        {s10_d, s1_d} = {set_sec10, set_sec1};
        rep_cnt_d     = rep_cnt;
        rep_per_d     = rep_per;
        step          = 1'b0;
        step_up       = 1'b0;
        if (blink_cnt == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase;
        end else begin
            blink_cnt_d   = blink_cnt + BW'(1);
            blink_phase_d = blink_phase;
        end

        if (state == RUN || mode_edge) begin
            rep_cnt_d     = '0;
            rep_per_d     = 1'b0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
            if (mode_edge) begin
                case (state)
                    RUN: begin
                        state_d       = SET_HR;
                        {h10_d, h1_d} = {cur_hour10, cur_hour1};
                        {m10_d, m1_d} = {cur_min10, cur_min1};
                        {s10_d, s1_d} = {cur_sec10, cur_sec1};
                    end
                    SET_HR:  state_d = SET_MIN;
                    SET_MIN: state_d = SET_SEC;
                    default: begin
                        state_d = RUN;
                        load_d  = 1'b1;
                    end
                endcase
            end
        end else if (btn_inc && btn_dec) begin
            rep_cnt_d = '0;
            rep_per_d = 1'b0;
        end else if (inc_edge || dec_edge) begin
            step      = 1'b1;
            step_up   = inc_edge;
            rep_cnt_d = '0;
            rep_per_d = 1'b0;
        end else if (btn_inc || btn_dec) begin
            // First repeat after the delay, then every period.
            step_up = btn_inc;
            if (rep_cnt == (rep_per ? PERIOD_LAST : DELAY_LAST)) begin
                step      = 1'b1;
                rep_cnt_d = '0;
                rep_per_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt + RW'(1);
            end
        end else begin
            rep_cnt_d = '0;
            rep_per_d = 1'b0;
        end

        if (step) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
            case (state)
                SET_HR:  {h10_d, h1_d} = bcd_step(set_hour10, set_hour1, 7'd23, step_up);
                SET_MIN: {m10_d, m1_d} = bcd_step(set_min10, set_min1, 7'd59, step_up);
                SET_SEC: {s10_d, s1_d} = bcd_step(set_sec10, set_sec1, 7'd59, step_up);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state       <= RUN;
            mode_q      <= 1'b1;
            inc_q       <= 1'b1;
            dec_q       <= 1'b1;
            load        <= 1'b0;
            {set_hour10, set_hour1, set_min10, set_min1, set_sec10, set_sec1} <= '0;
            rep_cnt     <= '0;
            rep_per     <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            state       <= state_d;
            mode_q      <= btn_mode;
            inc_q       <= btn_inc;
            dec_q       <= btn_dec;
            load        <= load_d;
            {set_hour10, set_hour1, set_min10, set_min1, set_sec10, set_sec1}
                        <= {h10_d, h1_d, m10_d, m1_d, s10_d, s1_d};
            rep_cnt     <= rep_cnt_d;
            rep_per     <= rep_per_d;
            blink_cnt   <= blink_cnt_d;
            blink_phase <= blink_phase_d;
        end
    end

    assign mode   = state;
    assign run_en = (state == RUN);

    always_comb begin
        blink_mask = 3'b000;
        case (state)
            SET_HR:  blink_mask = {blink_phase, 2'b00};
            SET_MIN: blink_mask = {1'b0, blink_phase, 1'b0};
            SET_SEC: blink_mask = {2'b00, blink_phase};
            default: blink_mask = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed walk through the setting sequence plus
// random button traffic, all checked against a field-level model every cycle.
module tb_clock_time_setter;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       resetn, btn_mode, btn_inc, btn_dec;
    logic [3:0] cur_sec1, cur_sec10, cur_min1, cur_min10, cur_hour1, cur_hour10;
    logic [3:0] set_sec1, set_sec10, set_min1, set_min10, set_hour1, set_hour10;
    logic       load, run_en;
    logic [1:0] mode;
    logic [2:0] blink_mask;

    clock_time_setter #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .BLINK_HALF(BH)) dut (
        .clk(clk), .resetn(resetn), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_sec1(cur_sec1), .cur_sec10(cur_sec10), .cur_min1(cur_min1),
        .cur_min10(cur_min10), .cur_hour1(cur_hour1), .cur_hour10(cur_hour10),
        .set_sec1(set_sec1), .set_sec10(set_sec10), .set_min1(set_min1),
        .set_min10(set_min10), .set_hour1(set_hour1), .set_hour10(set_hour10),
        .load(load), .run_en(run_en), .mode(mode), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int load_seen = 0;
    bit model_on = 1'b0;

    // Model: mode number, field values as integers, cycles held since the
    // last edge/clear, cycles since the blink last restarted.
    int m_mode, m_hh, m_mm, m_ss, m_n, m_age;
    bit m_load, p_m, p_i, p_d;

    function automatic int wrap_step(int v, int maxv, bit up);
        if (up) return (v == maxv) ? 0 : v + 1;
        return (v == 0) ? maxv : v - 1;
    endfunction

    task automatic model_field_step(bit up);
        case (m_mode)
            1: m_hh = wrap_step(m_hh, 23, up);
            2: m_mm = wrap_step(m_mm, 59, up);
            3: m_ss = wrap_step(m_ss, 59, up);
            default: ;
        endcase
        m_age = 0;
    endtask

    task automatic model_update();
        bit me, ie, de;
        if (resetn) begin
            m_mode = 0; m_load = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_n = 0; m_age = 0;
            p_m = 1; p_i = 1; p_d = 1;
            return;
        end
        me = btn_mode && !p_m;
        ie = btn_inc && !p_i;
        de = btn_dec && !p_d;
        m_load = 0;
        if (me) begin
            if (m_mode == 0) begin
                m_hh = int'(cur_hour10) * 10 + int'(cur_hour1);
                m_mm = int'(cur_min10) * 10 + int'(cur_min1);
                m_ss = int'(cur_sec10) * 10 + int'(cur_sec1);
                m_mode = 1;
            end else if (m_mode == 3) begin
                m_mode = 0;
                m_load = 1;
            end else begin
                m_mode = m_mode + 1;
            end
            m_n = 0;
            m_age = 0;
        end else if (m_mode == 0) begin
            m_n = 0;
            m_age = 0;
        end else if (btn_inc && btn_dec) begin
            m_n = 0;
            m_age++;
        end else if (ie || de) begin
            m_n = 0;
            model_field_step(ie);
        end else if (btn_inc || btn_dec) begin
            m_n++;
            m_age++;
            if (m_n >= RD && (m_n - RD) % RP == 0) model_field_step(btn_inc);
        end else begin
            m_n = 0;
            m_age++;
        end
        p_m = btn_mode; p_i = btn_inc; p_d = btn_dec;
    endtask

    task automatic compare_outputs();
        logic [30:0] exp_v, act_v;
        logic [2:0]  exp_mask;
        exp_mask = 3'b000;
        if (m_mode != 0 && ((m_age / BH) % 2) == 1) exp_mask[3 - m_mode] = 1'b1;
        exp_v = {2'(m_mode), (m_mode == 0), m_load, exp_mask,
                 4'(m_hh / 10), 4'(m_hh % 10), 4'(m_mm / 10), 4'(m_mm % 10),
                 4'(m_ss / 10), 4'(m_ss % 10)};
        act_v = {mode, run_en, load, blink_mask, set_hour10, set_hour1,
                 set_min10, set_min1, set_sec10, set_sec1};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, act_v, exp_v);
        end
        if (load === 1'b1) load_seen++;
    endtask

    always @(posedge clk) begin
        if (model_on) begin
            model_update();
            #1;
            compare_outputs();
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int hour_v(); return int'(set_hour10) * 10 + int'(set_hour1); endfunction
    function automatic int min_v();  return int'(set_min10) * 10 + int'(set_min1);  endfunction
    function automatic int sec_v();  return int'(set_sec10) * 10 + int'(set_sec1);  endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_mode = v;
            1: btn_inc = v;
            default: btn_dec = v;
        endcase
    endtask

    task automatic press(input int which, input int n);
        repeat (n) begin
            set_btn(which, 1'b1);
            @(negedge clk);
            set_btn(which, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour10 = 4'(h / 10); cur_hour1 = 4'(h % 10);
        cur_min10  = 4'(m / 10); cur_min1  = 4'(m % 10);
        cur_sec10  = 4'(s / 10); cur_sec1  = 4'(s % 10);
    endtask

    initial begin
        resetn = 1'b1; btn_mode = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0;
        set_cur(12, 34, 56);
        model_on = 1'b1;
        cyc(3);
        chk("reset_mode", int'(mode), 0);
        chk("reset_run_en", int'(run_en), 1);
        chk("reset_load_mask", int'({load, blink_mask}), 0);
        chk("reset_set", hour_v() + min_v() + sec_v(), 0);

        resetn = 1'b0;
        cyc(3);
        chk("hold_no_edge", int'(mode), 0);
        btn_mode = 1'b0;
        cyc(1);
        btn_mode = 1'b1;
        cyc(1);
        chk("enter_set_hr", int'(mode), 1);
        chk("enter_run_en", int'(run_en), 0);
        chk("capture", hour_v() * 10000 + min_v() * 100 + sec_v(), 123456);
        btn_mode = 1'b0;
        cyc(1);

        press(2, 13);
        chk("hour_dec_to_23", hour_v(), 23);
        press(1, 1);
        chk("hour_inc_wrap", hour_v(), 0);
        press(2, 1);
        chk("hour_dec_wrap", hour_v(), 23);
        press(2, 4);
        chk("hour_19", hour_v(), 19);
        press(1, 1);
        chk("hour_bcd_carry", int'({set_hour10, set_hour1}), 8'h20);

        btn_mode = 1'b1;
        @(negedge clk);
        chk("enter_set_min", int'(mode), 2);
        chk("blink_age0", int'(blink_mask), 0);
        btn_mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("blink_phase", int'(blink_mask), ((k / 4) % 2 == 1) ? 2 : 0);
        end
        btn_inc = 1'b1;
        @(negedge clk);
        chk("blink_step_restart", int'(blink_mask), 0);
        chk("min_inc", min_v(), 35);
        btn_inc = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("blink_after_step", int'(blink_mask), (k == 4) ? 2 : 0);
        end
        press(2, 35);
        chk("min_zero", min_v(), 0);
        press(2, 1);
        chk("min_dec_wrap", min_v(), 59);
        chk("others_hold", hour_v() * 100 + sec_v(), 2056);

        press(0, 1);
        chk("enter_set_sec", int'(mode), 3);
        press(1, 4);
        chk("sec_zero", sec_v(), 0);
        btn_inc = 1'b1;
        cyc(20);
        btn_inc = 1'b0;
        cyc(1);
        chk("auto_repeat", sec_v(), 5);
        btn_inc = 1'b1; btn_dec = 1'b1;
        cyc(20);
        btn_inc = 1'b0; btn_dec = 1'b0;
        cyc(1);
        chk("inc_dec_both", sec_v(), 5);

        load_seen = 0;
        btn_mode = 1'b1;
        @(negedge clk);
        chk("load_pulse", int'(load), 1);
        chk("load_mode_run", int'({mode, run_en}), 1);
        chk("load_set_value", hour_v() * 10000 + min_v() * 100 + sec_v(), 205905);
        btn_mode = 1'b0;
        @(negedge clk);
        chk("load_ends", int'(load), 0);
        chk("load_set_stable", hour_v() * 10000 + min_v() * 100 + sec_v(), 205905);
        cyc(4);
        chk("load_once", load_seen, 1);

        press(0, 2);
        chk("back_in_set_min", int'(mode), 2);
        press(1, 3);
        load_seen = 0;
        resetn = 1'b1;
        cyc(2);
        resetn = 1'b0;
        cyc(5);
        chk("reset_mid_edit_no_load", load_seen, 0);
        chk("reset_mid_edit_run", int'({mode, run_en}), 1);

        for (int i = 0; i < 4000; i++) begin
            set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            if ($urandom_range(0, 15) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 7) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 7) == 0) btn_dec = ~btn_dec;
            resetn = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        resetn = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
